// File: rtl/rd_wr_arb_pkg.sv
// Shared types and constants for the read/write command arbiter.
package rd_wr_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE} arb_state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rd_wr_arbiter_if.sv
// Client-request / downstream-command bundle between clients and the arbiter.
interface rd_wr_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_ack;
  logic              wr_ack;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ack, wr_ack, rd, wr, addr, wdata, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ack, wr_ack, rd, wr, addr, wdata, busy
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick; bit 0 is read, bit 1 is write.
module rr_pick2
  import rd_wr_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_t     last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    if (&req_i) gnt_o = (last_i == GRANT_WR) ? 2'b01 : 2'b10;
    else        gnt_o = req_i;
  end
endmodule

// File: rtl/rd_wr_arbiter.sv
// Serialises independent read/write requests onto one rd/wr command port,
// with a mandatory IDLE cycle between commands so rd and wr never overlap.
module rd_wr_arbiter
  import rd_wr_arb_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  rd_wr_arbiter_if.slave     bus
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  grant_t            last_q, last_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt;

  rr_pick2 u_pick (
    .req_i  ({bus.wr_req, bus.rd_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Outputs are computed for the next cycle so every port is a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    rd_ack_d = 1'b0;
    wr_ack_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          state_d  = READ;
          cnt_d    = CNT_LOAD;
          last_d   = GRANT_RD;
          rd_d     = 1'b1;
          rd_ack_d = (CNT_LOAD == '0);
          addr_d   = bus.rd_addr;
        end else if (gnt[1]) begin
          state_d  = WRITE;
          cnt_d    = CNT_LOAD;
          last_d   = GRANT_WR;
          wr_d     = 1'b1;
          wr_ack_d = (CNT_LOAD == '0);
          addr_d   = bus.wr_addr;
          wdata_d  = bus.wr_data;
        end
      end
      READ: begin
        if (cnt_q == '0) state_d = IDLE;
        else begin
          cnt_d    = cnt_q - CNT_W'(1);
          rd_d     = 1'b1;
          rd_ack_d = (cnt_q == CNT_W'(1));
        end
      end
      WRITE: begin
        if (cnt_q == '0) state_d = IDLE;
        else begin
          cnt_d    = cnt_q - CNT_W'(1);
          wr_d     = 1'b1;
          wr_ack_d = (cnt_q == CNT_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= GRANT_WR;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.rd     = rd_q;
  assign bus.wr     = wr_q;
  assign bus.rd_ack = rd_ack_q;
  assign bus.wr_ack = wr_ack_q;
  assign bus.busy   = busy_q;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;
endmodule

// File: tb/tb_rd_wr_arbiter.sv
// Directed bench for rd_wr_arbiter with ACCESS_CYCLES=2.
module tb_rd_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rd_wr_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rd_wr_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // {rd, wr, rd_ack, wr_ack, busy}
  function automatic logic [4:0] obs();
    return {bus.rd, bus.wr, bus.rd_ack, bus.wr_ack, bus.busy};
  endfunction

  task automatic test_reset();
    bus.rd_req = 0; bus.wr_req = 0;
    bus.rd_addr = 0; bus.wr_addr = 0; bus.wr_data = 0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if (obs() !== 5'b00000) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=00000", obs());
    end
    n_cmp++;
    if (bus.addr !== 8'h00 || bus.wdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_data got addr=%h wdata=%h exp 00/00", bus.addr, bus.wdata);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (obs() !== 5'b00000) begin
      n_bad++; $display("FAIL reset_idle got=%b exp=00000", obs());
    end
  endtask

  task automatic test_single_read();
    logic [4:0] exp [4] = '{5'b10001, 5'b10101, 5'b00000, 5'b00000};
    bus.rd_addr = 8'h3C; bus.rd_req = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[c]) begin
        n_bad++; $display("FAIL single_read c%0d got=%b exp=%b", c, obs(), exp[c]);
      end
      if (c < 2) begin
        n_cmp++;
        if (bus.addr !== 8'h3C) begin
          n_bad++; $display("FAIL single_read_addr c%0d got=%h exp=3c", c, bus.addr);
        end
      end
      if (bus.rd_ack) bus.rd_req = 0;
    end
  endtask

  task automatic test_single_write();
    logic [4:0] exp [3] = '{5'b01001, 5'b01011, 5'b00000};
    bus.wr_addr = 8'h10; bus.wr_data = 8'hA5; bus.wr_req = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[c]) begin
        n_bad++; $display("FAIL single_write c%0d got=%b exp=%b", c, obs(), exp[c]);
      end
      if (c < 2) begin
        n_cmp++;
        if (bus.addr !== 8'h10 || bus.wdata !== 8'hA5) begin
          n_bad++; $display("FAIL single_write_data c%0d got=%h/%h exp=10/a5", c, bus.addr, bus.wdata);
        end
      end
      if (bus.wr_ack) bus.wr_req = 0;
    end
  endtask

  task automatic test_conflict();
    logic [4:0] exp [6] = '{5'b10001, 5'b10101, 5'b00000, 5'b01001, 5'b01011, 5'b00000};
    do_reset();
    bus.rd_addr = 8'h3C; bus.wr_addr = 8'h20; bus.wr_data = 8'h5A;
    bus.rd_req = 1; bus.wr_req = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[c] || (bus.rd && bus.wr)) begin
        n_bad++; $display("FAIL conflict c%0d got=%b exp=%b", c, obs(), exp[c]);
      end
      if (bus.rd_ack) bus.rd_req = 0;
      if (bus.wr_ack) bus.wr_req = 0;
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp [12] = '{5'b10001, 5'b10101, 5'b00000, 5'b01001, 5'b01011, 5'b00000,
                             5'b10001, 5'b10101, 5'b00000, 5'b01001, 5'b01011, 5'b00000};
    int acks = 0;
    do_reset();
    bus.rd_req = 1; bus.wr_req = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[c] || (bus.rd && bus.wr)) begin
        n_bad++; $display("FAIL contention c%0d got=%b exp=%b", c, obs(), exp[c]);
      end
      acks += int'(bus.rd_ack) + int'(bus.wr_ack);
      bus.rd_req = !bus.rd_ack;
      bus.wr_req = !bus.wr_ack;
    end
    bus.rd_req = 0; bus.wr_req = 0;
    n_cmp++;
    if (acks !== 4) begin
      n_bad++; $display("FAIL contention_acks got=%0d exp=4", acks);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp [5] = '{5'b10101, 5'b00000, 5'b01001, 5'b01011, 5'b00000};
    bus.wr_addr = 8'h10; bus.wr_data = 8'hA5; bus.wr_req = 1;
    tick();
    n_cmp++;
    if (obs() !== 5'b01001) begin
      n_bad++; $display("FAIL reset_mid_first got=%b exp=01001", obs());
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== 5'b00000 || bus.addr !== 8'h00 || bus.wdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_mid_drop got=%b addr=%h wdata=%h exp=00000/00/00", obs(), bus.addr, bus.wdata);
    end
    rst = 1'b0;
    bus.rd_addr = 8'h44; bus.rd_req = 1;
    tick();
    n_cmp++;
    if (obs() !== 5'b10001 || bus.addr !== 8'h44) begin
      n_bad++; $display("FAIL reset_mid_rdfirst got=%b addr=%h exp=10001/44", obs(), bus.addr);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[c]) begin
        n_bad++; $display("FAIL reset_mid_seq c%0d got=%b exp=%b", c, obs(), exp[c]);
      end
      if (bus.rd_ack) bus.rd_req = 0;
      if (bus.wr_ack) bus.wr_req = 0;
    end
  endtask

  task automatic test_input_change();
    bus.rd_addr = 8'h3C; bus.rd_req = 1;
    tick();
    n_cmp++;
    if (bus.addr !== 8'h3C || bus.rd !== 1'b1) begin
      n_bad++; $display("FAIL hold_addr_c0 got addr=%h rd=%b exp=3c/1", bus.addr, bus.rd);
    end
    bus.rd_addr = 8'h55;
    tick();
    n_cmp++;
    if (bus.addr !== 8'h3C || bus.rd_ack !== 1'b1) begin
      n_bad++; $display("FAIL hold_addr_c1 got addr=%h ack=%b exp=3c/1", bus.addr, bus.rd_ack);
    end
    n_cmp++;
    if (bus.wdata !== 8'hA5) begin
      n_bad++; $display("FAIL hold_wdata got=%h exp=a5", bus.wdata);
    end
    bus.rd_req = 0;
    tick();
    n_cmp++;
    if (obs() !== 5'b00000 || bus.addr !== 8'h3C) begin
      n_bad++; $display("FAIL hold_addr_idle got=%b addr=%h exp=00000/3c", obs(), bus.addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_conflict();
    test_contention();
    test_reset_mid();
    test_input_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rd_wr_arbiter.md
# rd_wr_arbiter

Two-client request arbiter in front of the single-port memory interface. It accepts independent read and write requests and serialises them onto one `rd`/`wr` command port. The rule "read and write request must not occur at same time" holds on its outputs by construction. The downstream command port and its `rd |-> !wr` property check consume its outputs directly.

## Interface
Parameters:
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: write data width.
- `ACCESS_CYCLES`, default 2: cycles each `rd`/`wr` command is held. Legal range is 1..15.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rd_req` in 1: read request (level); held until `rd_ack`.
- `rd_addr` in ADDR_W: read address; stable while `rd_req` is high.
- `wr_req` in 1: write request (level); held until `wr_ack`.
- `wr_addr` in ADDR_W: write address; stable while `wr_req` is high.
- `wr_data` in DATA_W: write data; stable while `wr_req` is high.
- `rd_ack` out 1: one-cycle pulse on the last read command cycle.
- `wr_ack` out 1: one-cycle pulse on the last write command cycle.
- `rd` out 1: read command to downstream.
- `wr` out 1: write command to downstream.
- `addr` out ADDR_W: latched address of the current command.
- `wdata` out DATA_W: latched write data; holds its last value during reads.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM states are IDLE, READ and WRITE. All outputs are registered.
- IDLE, neither request: stay in IDLE.
- IDLE, only `rd_req`: latch `rd_addr` and go to READ.
- IDLE, only `wr_req`: latch `wr_addr`/`wr_data` and go to WRITE.
- IDLE, both requests: round-robin. Grant the opposite of `last_grant`, then update `last_grant`. `last_grant` resets to WRITE, so the first conflict goes to READ.
- READ/WRITE:
  - Assert `rd` (resp. `wr`) for exactly ACCESS_CYCLES cycles.
  - A down-counter is loaded with ACCESS_CYCLES-1 on grant. Counter width is 4 bits.
  - When the counter is 0, pulse the matching ack in that cycle, then go to IDLE.
- IDLE always lasts at least one cycle between commands. `rd` and `wr` are therefore never both high, and never back-to-back without a gap.
- A request still high in the IDLE cycle after its ack is treated as a new request. Clients must drop `req` on the edge where they sample ack high.
- Changes to `addr`/`data` inputs during READ/WRITE have no effect on outputs.
- Reset values: `rd`=0, `wr`=0, `rd_ack`=0, `wr_ack`=0, `busy`=0, `addr`=0, `wdata`=0, `last_grant`=WRITE, state=IDLE, counter=0.

## Timing
- Latency: a request sampled high in IDLE at edge N drives `rd`/`wr` high from edge N+1 through edge N+ACCESS_CYCLES.
- The ack is high for the cycle that starts at edge N+ACCESS_CYCLES. The FSM is back in IDLE after edge N+ACCESS_CYCLES+1.
- Throughput: one command per ACCESS_CYCLES+1 cycles.
- Simultaneous arrival: handled only by the round-robin rule. A request arriving mid-command waits; it is evaluated in the next IDLE cycle.
- Starvation: with both requests held continuously, grants alternate R, W, R, W.
- Reset mid-command: `rst` high at any edge forces all outputs to their reset values on that edge. The in-flight command is dropped with no ack, and the client must re-request.
- Reset has priority over every other transition.
- ACCESS_CYCLES=1: each command lasts one cycle, and its ack coincides with the only command cycle.

## Structure
- Shared package `rd_wr_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, READ, WRITE} arb_state_t`
  - `typedef enum logic {GRANT_RD, GRANT_WR} grant_t`
  - constant `CNT_W` = 4
- One natural sub-module, `rr_pick2`: the combinational two-way round-robin selector. It takes `req[1:0]` and `last` and produces a one-hot `gnt[1:0]`. `last_grant` is updated in the parent.
- Everything else (FSM, counter, latches) lives in `rd_wr_arbiter`.

## Test plan
All scenarios use ACCESS_CYCLES=2.
- Single read: `rd_req`=1, `rd_addr`=0x3C from IDLE -> `rd`=1 and `addr`=0x3C for 2 cycles; `rd_ack` on the 2nd; `wr` stays 0; then 1 IDLE cycle.
- Single write: `wr_req`=1, `wr_addr`=0x10, `wr_data`=0xA5 -> `wr`=1, `addr`=0x10, `wdata`=0xA5 for 2 cycles; `wr_ack` on the 2nd.
- Conflict after reset: `rd_req` and `wr_req` rise on the same edge -> READ first (`rd_ack`), one IDLE cycle, then WRITE (`wr_ack`). `rd`&`wr` is never 1 in any cycle.
- Sustained contention: both requests held for 12 cycles, clients re-asserting after each ack -> grant sequence R, W, R, W; 4 acks total; a 1-cycle gap between each command.
- Reset mid-command: `rst`=1 on the 2nd `wr` cycle -> `wr`=0, `wr_ack`=0, `busy`=0, `addr`=0 on that edge. A following conflict grants READ first.
- Input change during command: `rd_addr` changes 0x3C->0x55 while READ is active -> `addr` remains 0x3C until ack.
